// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM responder: FSM encoding, data/counter widths and the parity helper.
package dram_pkg;

  localparam int DATA_W    = 8;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dram_state_t;

  // Even parity bit: makes the total number of ones in {parity, data} even.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dram_array.sv
// Synchronous single-port storage array: one write or one registered read per edge, no reset.
module dram_array #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  logic [WORD_W-1:0] r_rdata;

  // The read register only moves on a read, so it holds the last read word indefinitely.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_ctrl.sv
// Memory-side responder with a fixed wait-state latency in front of dram_array.
// Optional read parity checking is enabled by defining DRAM_PARITY_EN.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_memory,
  input  logic              write_memory,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_write_DRAM,
  output logic [7:0]        data_read_DRAM,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              parity_err
);

`ifdef DRAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  dram_state_t          r_state;
  dram_state_t          w_next;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_op_rd;
  logic                 r_rd_vld;
  logic                 w_req;
  logic                 w_commit;
  logic                 w_we;
  logic                 w_re;
  logic [WORD_W-1:0]    w_wword;
  logic [WORD_W-1:0]    w_rword;

  assign w_req = read_memory | write_memory;

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      IDLE: if (w_req) w_next = BUSY;
      BUSY: begin
        if (r_cnt == '0) begin
          w_commit = 1'b1;
          w_next   = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op_rd  <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_cnt   <= LAT_CNT_W'(LATENCY - 1);
        r_op_rd <= read_memory;
      end else if (r_state == BUSY && !w_commit) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit && r_op_rd) begin
        r_rd_vld <= 1'b1;
      end
    end
  end

  // Address is a datapath register: captured only at accept, never reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_req) begin
      r_addr <= address;
    end
  end

  // Gating with rst makes a reset on the commit edge abort the access cleanly.
  assign w_we = w_commit & ~r_op_rd & ~rst;
  assign w_re = w_commit &  r_op_rd & ~rst;

`ifdef DRAM_PARITY_EN
  assign w_wword    = {even_par(data_write_DRAM), data_write_DRAM};
  assign parity_err = (r_state == DONE) & r_op_rd & (^w_rword);
`else
  assign w_wword    = data_write_DRAM;
  assign parity_err = 1'b0;
`endif

  dram_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr),
    .i_wdata (w_wword),
    .o_rdata (w_rword)
  );

  // The array has no reset, so the read output is masked until the first read after reset.
  assign data_read_DRAM = r_rd_vld ? w_rword[DATA_W-1:0] : 8'h00;
  assign mem_busy       = (r_state == BUSY);
  assign mem_done       = (r_state == DONE);

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: a LATENCY=3 and a LATENCY=1 instance checked against a byte-map model.
module tb_dram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tb_rd   [2];
  logic        tb_wr   [2];
  logic [15:0] tb_addr [2];
  logic [7:0]  tb_wd   [2];
  logic [7:0]  w_rdata [2];
  logic        w_busy  [2];
  logic        w_done  [2];
  logic        w_perr  [2];

  int total = 0;
  int bad   = 0;
  int done_cnt [2];
  logic [7:0] mdl [int];
  logic [7:0] last_rd [2];

  always #5 clk = ~clk;

  dram_ctrl #(.ADDR_W(16), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .read_memory(tb_rd[0]), .write_memory(tb_wr[0]),
    .address(tb_addr[0]), .data_write_DRAM(tb_wd[0]), .data_read_DRAM(w_rdata[0]),
    .mem_busy(w_busy[0]), .mem_done(w_done[0]), .parity_err(w_perr[0]));

  dram_ctrl #(.ADDR_W(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .read_memory(tb_rd[1]), .write_memory(tb_wr[1]),
    .address(tb_addr[1]), .data_write_DRAM(tb_wd[1]), .data_read_DRAM(w_rdata[1]),
    .mem_busy(w_busy[1]), .mem_done(w_done[1]), .parity_err(w_perr[1]));

  always @(negedge clk) begin
    if (w_done[0] === 1'b1) done_cnt[0]++;
    if (w_done[1] === 1'b1) done_cnt[1]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int key(input int inst, input logic [15:0] a);
    return inst * 65536 + int'(a);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_rdata"}, w_rdata[k], 0);
      chk({tag, "_busy"},  w_busy[k],  0);
      chk({tag, "_done"},  w_done[k],  0);
      chk({tag, "_perr"},  w_perr[k],  0);
    end
  endtask

  // One complete access; hold keeps the request asserted through BUSY/DONE to prove it is ignored.
  task automatic access(input int inst, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] wd, input bit hold, input logic exp_perr);
    int n;
    int busy;
    int lat;
    lat = (inst == 0) ? 3 : 1;
    @(negedge clk);
    tb_rd[inst] = rd; tb_wr[inst] = wr; tb_addr[inst] = a; tb_wd[inst] = wd;
    @(posedge clk); #1;
    if (!hold) begin
      tb_rd[inst] = 1'b0; tb_wr[inst] = 1'b0;
      tb_addr[inst] = 16'($urandom);
    end
    n = 0; busy = 0;
    while (w_done[inst] !== 1'b1 && n < 40) begin
      if (w_busy[inst] === 1'b1) busy++;
      @(posedge clk); #1;
      n++;
    end
    chk("no_timeout", (n < 40), 1);
    chk("done_latency", n, lat);
    chk("busy_cycles", busy, lat);
    chk("busy_low_in_done", w_busy[inst], 0);
    if (rd) begin
      last_rd[inst] = mdl.exists(key(inst, a)) ? mdl[key(inst, a)] : 8'hxx;
    end else if (wr) begin
      mdl[key(inst, a)] = wd;
    end
    chk("rdata", w_rdata[inst], last_rd[inst]);
    chk("parity_err", w_perr[inst], exp_perr);
    tb_rd[inst] = 1'b0; tb_wr[inst] = 1'b0;
    @(posedge clk); #1;
    chk("done_single_pulse", w_done[inst], 0);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tb_rd[k] = 1'b0; tb_wr[k] = 1'b0; tb_addr[k] = '0; tb_wd[k] = '0;
      done_cnt[k] = 0; last_rd[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_init");
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of a write aborts it
    access(0, 1'b0, 1'b1, 16'h0004, 8'h77, 1'b0, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0004, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    tb_wr[0] = 1'b1; tb_addr[0] = 16'h0004; tb_wd[0] = 8'h3C;
    @(posedge clk); #1;
    tb_wr[0] = 1'b0;
    chk("busy_before_reset", w_busy[0], 1);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_mid_busy");
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    @(negedge clk); rst = 1'b0;
    access(0, 1'b1, 1'b0, 16'h0004, 8'h00, 1'b0, 1'b0);

    // Basic write/read with LATENCY=3
    access(0, 1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0);

    // Back-to-back with requests held high during BUSY/DONE
    d0 = done_cnt[0];
    access(0, 1'b0, 1'b1, 16'h0001, 8'h11, 1'b1, 1'b0);
    access(0, 1'b0, 1'b1, 16'h0002, 8'h22, 1'b1, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0001, 8'h00, 1'b1, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0002, 8'h00, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_count", done_cnt[0] - d0, 4);

    // Simultaneous read and write: read wins, write dropped
    access(0, 1'b0, 1'b1, 16'h0020, 8'h5A, 1'b0, 1'b0);
    access(0, 1'b1, 1'b1, 16'h0020, 8'hFF, 1'b0, 1'b0);
    access(0, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b0);

    // Boundaries on the LATENCY=1 instance
    access(1, 1'b0, 1'b1, 16'h0000, 8'h3E, 1'b0, 1'b0);
    access(1, 1'b0, 1'b1, 16'hFFFF, 8'h80, 1'b0, 1'b0);
    access(1, 1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b0);
    access(1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

    // Randomized traffic on both instances
    for (int i = 0; i < 40; i++) begin
      int inst;
      logic [15:0] a;
      logic [7:0]  wd;
      int op;
      inst = int'($urandom_range(0, 1));
      a    = 16'h0100 + 16'($urandom_range(0, 15));
      wd   = 8'($urandom);
      op   = int'($urandom_range(0, 2));
      if (!mdl.exists(key(inst, a)) || op == 0)
        access(inst, 1'b0, 1'b1, a, wd, 1'b0, 1'b0);
      else if (op == 1)
        access(inst, 1'b1, 1'b0, a, wd, 1'b0, 1'b0);
      else
        access(inst, 1'b1, 1'b1, a, wd, 1'b0, 1'b0);
    end

`ifdef DRAM_PARITY_EN
    // Corrupted parity bit is reported, data still returned
    access(0, 1'b0, 1'b1, 16'h0030, 8'h5C, 1'b0, 1'b0);
    u_dut3.u_array.r_mem[16'h0030][8] = ~u_dut3.u_array.r_mem[16'h0030][8];
    access(0, 1'b1, 1'b0, 16'h0030, 8'h00, 1'b0, 1'b1);
    access(0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
